// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: size/state encodings and request legality helper for the load/store unit
package mem_access_unit_pkg;
  localparam int MEM_DEPTH_DEF = 64;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ERR, RESP} state_t;
  function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_access_unit_lane_align: little-endian lane extract/extend for loads and lane merge for stores
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] lane, mask;
  always_comb begin
    sh     = {off, 3'b000};
    lane   = word >> sh;
    mask   = (size == SZ_B ? 32'h0000_00ff : size == SZ_H ? 32'h0000_ffff : 32'hffff_ffff) << sh;
    ldata  = size == SZ_B ? {{24{~uns & lane[7]}}, lane[7:0]}
           : size == SZ_H ? {{16{~uns & lane[15]}}, lane[15:0]}
           : word;
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end with alignment/range checks and sub-word read-modify-write
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q, uns_q, err_q, req_err, accept;
  logic [DATA_W-1:0] wdata_q, old_q, rdata_q, word_in, ldata, merged;

  assign req_err = bad_size_align(req_size, req_addr[1:0]) ||
                   (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_DEPTH));
  assign accept  = req_valid & req_ready;
  // RD extracts straight from memory; RMW_WR merges into the word captured in RMW_RD
  assign word_in = state == RD ? mem_rdata : old_q;

  mem_access_unit_lane_align u_lane (
    .size   (size_q),
    .off    (addr_q[1:0]),
    .uns    (uns_q),
    .word   (word_in),
    .wdata  (wdata_q),
    .ldata  (ldata),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:                 if (req_valid) state_n = req_err ? ERR : !req_we ? RD : req_size == SZ_W ? WR : RMW_RD;
      RMW_RD:               state_n = RMW_WR;
      RD, WR, RMW_WR, ERR:  state_n = RESP;
      default:              state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = state == IDLE;
    busy       = ~req_ready;
    resp_valid = state == RESP;
    resp_err   = resp_valid & err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    mem_read   = state == RD || state == RMW_RD;
    mem_write  = state == WR || state == RMW_WR;
    mem_addr   = {2'b00, addr_q[ADDR_W-1:2]};
    mem_wdata  = state == WR ? wdata_q : state == RMW_WR ? merged : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == RD) rdata_q <= ldata;
      if (state == RMW_RD) old_q <= mem_rdata;
    end
  end

  logic unused_we;
  assign unused_we = we_q;
endmodule
